// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and grant codes for the unified-memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
endpackage

// File: rtl/flopenr.sv
// flopenr: enabled register with asynchronous active-high reset
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch (I) and memory-stage (D) ports
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          stall_f,
  output logic          stall_m,
  output logic          grant_d
);
  arb_state_t    state;
  logic          last_d, win_d, take, cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  // D wins unless I also asks and D had the previous slot
  assign win_d   = d_req & (~i_req | ~last_d);
  assign take    = (state == IDLE) & (i_req | d_req);
  assign m_we    = m_req & cap_we;
  assign m_addr  = cap_addr;
  assign m_wdata = cap_wdata;
  assign stall_f = i_req & ~i_ready;
  assign stall_m = d_req & ~d_ready;
  flopenr #(.WIDTH(AW)) addr_reg (.clk(clk), .reset(reset), .en(take), .d(win_d ? d_addr : i_addr), .q(cap_addr));
  flopenr #(.WIDTH(1)) we_reg (.clk(clk), .reset(reset), .en(take), .d(win_d & d_we), .q(cap_we));
  flopenr #(.WIDTH(DW)) wdata_reg (.clk(clk), .reset(reset), .en(take), .d(win_d ? d_wdata : '0), .q(cap_wdata));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      grant_d <= GNT_I;
      last_d  <= 1'b0;
      m_req   <= 1'b0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: if (take) begin
          grant_d <= win_d ? GNT_D : GNT_I;
          m_req   <= 1'b1;
          state   <= BUSY;
        end
        BUSY: if (m_ack) begin
          m_req   <= 1'b0;
          last_d  <= grant_d;
          i_ready <= ~grant_d;
          d_ready <= grant_d;
          if (grant_d && !cap_we) d_rdata <= m_rdata;
          if (!grant_d) i_rdata <= m_rdata;
          state   <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (I port, read-only) and the memory stage (D port, read/write) of the pipelined MIPS core.
- Sequences each access over a req/ack memory handshake with variable latency.
- Returns data and a one-cycle ready pulse to the winning port.
- Generates the stall_f / stall_m signals that the hazard logic uses to freeze the pipeline.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch read request; held until i_ready.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetch read data; valid while i_ready=1.
- i_ready  out  1  one-cycle completion pulse for the fetch access.
- d_req  in  1  data access request; held until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  data read result.
- d_ready  out  1  one-cycle completion pulse for the data access.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data; valid with m_ack.
- m_ack  in  1  memory completion; may arrive in the first m_req cycle or later.
- stall_f  out  1  i_req & ~i_ready.
- stall_m  out  1  d_req & ~d_ready.
- grant_d  out  1  1 while the current or last transaction belongs to D.

Behaviour:
- Reset values: state IDLE, all outputs 0, last_d=0, capture registers 0.
- FSM states:
  - IDLE: arbitrate.
    - Only d_req -> D. Only i_req -> I.
    - Both -> D if last_d=0, else I. This alternates grants under contention, with D winning first after reset.
    - On a grant: register addr/we/wdata from the winner, set grant_d, go to BUSY.
  - BUSY:
    - m_req=1; m_addr/m_we/m_wdata come from the capture registers and stay stable for the whole state.
    - m_we=0 for I grants.
    - On m_ack: capture m_rdata into the winner's rdata register (reads only), set last_d=grant_d, go to RESP.
  - RESP:
    - Assert winner's ready=1 for exactly this cycle; no arbitration, m_req=0; go to IDLE.
- Latency: request sampled in IDLE at cycle n -> m_req at n+1.
  - m_ack at n+1+k (k>=0) -> ready at n+2+k.
  - Minimum 3 cycles per access, back-to-back.
- Requester protocol:
  - Requester changes addr/req only in the cycle after its ready pulse.
  - Inputs are not re-sampled while the port is in BUSY/RESP.
  - A requester dropping req before ready is illegal; the transaction still completes.
- rdata registers:
  - i_rdata/d_rdata hold the last read value until the next read on that port.
  - D writes leave d_rdata unchanged and still pulse d_ready.
- m_ack outside BUSY is ignored, with no state change.
- i_ready and d_ready are never both 1.
- stall_f and stall_m are combinational; stall_f=1 while I waits behind a D transaction.
- Reset mid-transaction: m_req falls immediately (asynchronous). The transaction is abandoned with no ready pulse, and a late m_ack after release is ignored.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, BUSY, RESP};
  - localparam GNT_I=1'b0, GNT_D=1'b1.
- Capture registers reuse the existing flopenr.
- No new sub-module; the FSM and arbitration live in one module.

Test Plan:
- Single I read:
  - Stimulus: i_req=1, i_addr=0x0000_0040; m_ack in the first m_req cycle with m_rdata=0x2008_0005.
  - Response: m_req one cycle after the request, i_ready pulse 2 cycles after the request, i_rdata=0x2008_0005, stall_f 1 until the i_ready cycle.
- D write with 3-cycle wait:
  - Stimulus: d_req=1, d_we=1, d_addr=0x54, d_wdata=0x7; m_ack asserted in the 3rd m_req cycle.
  - Response: m_we=1, m_addr=0x54, m_wdata=0x7 stable for all 3 m_req cycles; d_ready once; d_rdata unchanged.
- Contention after reset:
  - Stimulus: i_req and d_req both held.
  - Response: grant order D, I, D, I over 4 transactions; stall_f=1 throughout the first D transaction.
- Spurious ack:
  - Stimulus: m_ack=1 in IDLE and in RESP.
  - Response: no ready pulse, no state change, rdata registers unchanged.
- Reset mid-access:
  - Stimulus: assert reset in BUSY with m_ack pending, release, then pulse m_ack.
  - Response: m_req=0 the same cycle; no ready pulse; state IDLE; all outputs 0.
- Back-to-back I reads:
  - Stimulus: i_addr 0x0, 0x4, 0x8 with zero-wait acks.
  - Response: i_ready pulses every 3 cycles with the matching m_rdata values.
